// File: rtl/pe_conv1d_sync.sv
// Clocked 1-D convolution processing element: filter and ifmap register files,
// output-stationary MAC loop with stride, optional partial-sum add, valid/ready I/O.
module pe_conv1d_sync #(
    parameter int DW      = 8,
    parameter int PSW     = 20,
    parameter int IF_LEN  = 5,
    parameter int FLT_LEN = 3,
    parameter int NUM_FLT = 1,
    parameter int STRIDE  = 1,
    localparam int FSZ    = FLT_LEN * NUM_FLT,
    localparam int MSZ    = (IF_LEN > FSZ) ? IF_LEN : FSZ,
    localparam int AW     = (MSZ > 1) ? $clog2(MSZ) : 1,
    localparam int FW     = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flt_valid,
    output logic           flt_ready,
    input  logic [AW-1:0]  flt_addr,
    input  logic [DW-1:0]  flt_data,
    input  logic           if_valid,
    output logic           if_ready,
    input  logic [AW-1:0]  if_addr,
    input  logic [DW-1:0]  if_data,
    input  logic           start,
    input  logic           use_psum,
    output logic           busy,
    input  logic           psum_in_valid,
    output logic           psum_in_ready,
    input  logic [PSW-1:0] psum_in_data,
    output logic           psum_out_valid,
    input  logic           psum_out_ready,
    output logic [PSW-1:0] psum_out_data,
    output logic [AW-1:0]  psum_out_idx,
    output logic [FW-1:0]  psum_out_flt,
    output logic           done
);

    localparam int OUT_LEN = (IF_LEN - FLT_LEN) / STRIDE + 1;
    localparam int DEPTH   = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_PSUM, S_OUT, S_DONE} state_t;

    state_t          state;
    logic [DW-1:0]   flt_mem [DEPTH];
    logic [DW-1:0]   if_mem  [DEPTH];
    logic [AW-1:0]   k, o;
    logic [FW-1:0]   f;
    logic [PSW-1:0]  acc;
    logic            use_psum_q;
    logic [AW-1:0]   flt_rd, if_rd;
    logic [2*DW-1:0] prod;

    // Ready is also gated by reset so every output reads 0 while rst_n is low.
    assign flt_ready     = (state == S_IDLE) && rst_n;
    assign if_ready      = (state == S_IDLE) && rst_n;
    assign psum_in_ready = (state == S_PSUM);

    always_comb begin
        flt_rd = AW'(32'(f) * FLT_LEN + 32'(k));
        if_rd  = AW'(32'(o) * STRIDE + 32'(k));
        prod   = (2*DW)'(flt_mem[flt_rd]) * (2*DW)'(if_mem[if_rd]);
    end

    // NOTE: the register files are plain flops cleared by reset, so a reset
    // wipes loaded weights; a RAM macro would not give that guarantee.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_mem <= '{default: '0};
            if_mem  <= '{default: '0};
        end else begin
            if (flt_valid && flt_ready && 32'(flt_addr) < FSZ)
                flt_mem[flt_addr] <= flt_data;
            if (if_valid && if_ready && 32'(if_addr) < IF_LEN)
                if_mem[if_addr] <= if_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every branch
    // reads the pre-edge values of acc, counters and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            k              <= '0;
            o              <= '0;
            f              <= '0;
            acc            <= '0;
            use_psum_q     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            psum_out_valid <= 1'b0;
            psum_out_data  <= '0;
            psum_out_idx   <= '0;
            psum_out_flt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_MAC;
                        acc        <= '0;
                        k          <= '0;
                        o          <= '0;
                        f          <= '0;
                        use_psum_q <= use_psum;
                        busy       <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc + PSW'(prod);
                    if (32'(k) == FLT_LEN - 1) begin
                        k     <= '0;
                        state <= use_psum_q ? S_PSUM : S_OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_PSUM: begin
                    if (psum_in_valid) begin
                        acc   <= acc + psum_in_data;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    // First OUT cycle registers the result; later cycles wait for the sink.
                    if (!psum_out_valid) begin
                        psum_out_valid <= 1'b1;
                        psum_out_data  <= acc;
                        psum_out_idx   <= o;
                        psum_out_flt   <= f;
                    end else if (psum_out_ready) begin
                        psum_out_valid <= 1'b0;
                        acc            <= '0;
                        if (32'(o) < OUT_LEN - 1) begin
                            o     <= o + 1'b1;
                            state <= S_MAC;
                        end else if (32'(f) < NUM_FLT - 1) begin
                            o     <= '0;
                            f     <= f + 1'b1;
                            state <= S_MAC;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_conv1d_sync.sv
// Self-checking bench for pe_conv1d_sync: a stride-1 instance with 16-bit psums
// and a stride-2, two-filter instance, each with its own result scoreboard.
module tb_pe_conv1d_sync;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int FW = 1;

    typedef struct {
        logic [31:0] data;
        int          idx;
        int          flt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int a_done_cnt = 0;
    int b_done_cnt = 0;

    // instance A: STRIDE=1, NUM_FLT=1, PSW=16
    logic          a_flt_valid = 0, a_flt_ready;
    logic [AW-1:0] a_flt_addr = '0;
    logic [DW-1:0] a_flt_data = '0;
    logic          a_if_valid = 0, a_if_ready;
    logic [AW-1:0] a_if_addr = '0;
    logic [DW-1:0] a_if_data = '0;
    logic          a_start = 0, a_use_psum = 0, a_busy, a_done;
    logic          a_pin_valid = 0, a_pin_ready;
    logic [15:0]   a_pin_data = '0;
    logic          a_out_valid, a_out_ready = 1;
    logic [15:0]   a_out_data;
    logic [AW-1:0] a_out_idx;
    logic [FW-1:0] a_out_flt;

    pe_conv1d_sync #(.PSW(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .flt_valid(a_flt_valid), .flt_ready(a_flt_ready), .flt_addr(a_flt_addr), .flt_data(a_flt_data),
        .if_valid(a_if_valid), .if_ready(a_if_ready), .if_addr(a_if_addr), .if_data(a_if_data),
        .start(a_start), .use_psum(a_use_psum), .busy(a_busy),
        .psum_in_valid(a_pin_valid), .psum_in_ready(a_pin_ready), .psum_in_data(a_pin_data),
        .psum_out_valid(a_out_valid), .psum_out_ready(a_out_ready), .psum_out_data(a_out_data),
        .psum_out_idx(a_out_idx), .psum_out_flt(a_out_flt), .done(a_done)
    );

    // instance B: STRIDE=2, NUM_FLT=2, PSW=20
    logic          b_flt_valid = 0, b_flt_ready;
    logic [AW-1:0] b_flt_addr = '0;
    logic [DW-1:0] b_flt_data = '0;
    logic          b_if_valid = 0, b_if_ready;
    logic [AW-1:0] b_if_addr = '0;
    logic [DW-1:0] b_if_data = '0;
    logic          b_start = 0, b_use_psum = 0, b_busy, b_done;
    logic          b_pin_valid = 0, b_pin_ready;
    logic [19:0]   b_pin_data = '0;
    logic          b_out_valid, b_out_ready = 1;
    logic [19:0]   b_out_data;
    logic [AW-1:0] b_out_idx;
    logic [FW-1:0] b_out_flt;

    pe_conv1d_sync #(.STRIDE(2), .NUM_FLT(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .flt_valid(b_flt_valid), .flt_ready(b_flt_ready), .flt_addr(b_flt_addr), .flt_data(b_flt_data),
        .if_valid(b_if_valid), .if_ready(b_if_ready), .if_addr(b_if_addr), .if_data(b_if_data),
        .start(b_start), .use_psum(b_use_psum), .busy(b_busy),
        .psum_in_valid(b_pin_valid), .psum_in_ready(b_pin_ready), .psum_in_data(b_pin_data),
        .psum_out_valid(b_out_valid), .psum_out_ready(b_out_ready), .psum_out_data(b_out_data),
        .psum_out_idx(b_out_idx), .psum_out_flt(b_out_flt), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: results are compared on the negedge before the accepting edge.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            exp_t e;
            e = (q_a.size() > 0) ? q_a.pop_front() : '{data: 32'hDEAD_BEEF, idx: -1, flt: -1};
            check("a_out_data", 32'(a_out_data), e.data);
            check("a_out_idx", 32'(a_out_idx), 32'(e.idx));
            check("a_out_flt", 32'(a_out_flt), 32'(e.flt));
        end
        if (b_out_valid && b_out_ready) begin
            exp_t e;
            e = (q_b.size() > 0) ? q_b.pop_front() : '{data: 32'hDEAD_BEEF, idx: -1, flt: -1};
            check("b_out_data", 32'(b_out_data), e.data);
            check("b_out_idx", 32'(b_out_idx), 32'(e.idx));
            check("b_out_flt", 32'(b_out_flt), 32'(e.flt));
        end
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    task automatic a_write(input logic fv, input int fa, input int fd,
                           input logic iv, input int ia, input int id);
        a_flt_valid = fv; a_flt_addr = AW'(fa); a_flt_data = DW'(fd);
        a_if_valid  = iv; a_if_addr  = AW'(ia); a_if_data  = DW'(id);
        tick();
        a_flt_valid = 0; a_if_valid = 0;
    endtask

    task automatic a_load_basic();
        for (int i = 0; i < 5; i++) a_write(i < 3, i, i + 1, 1'b1, i, i + 1);
    endtask

    task automatic a_push(input logic [31:0] d, input int idx);
        q_a.push_back('{data: d, idx: idx, flt: 0});
    endtask

    task automatic a_start_run(input logic up);
        a_use_psum = up; a_start = 1;
        tick();
        a_start = 0; a_use_psum = 0;
    endtask

    task automatic a_wait_valid(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 100) begin tick(); lat++; end
    endtask

    task automatic a_wait_done(input string tag, input int exp_cnt);
        int n = 0;
        while (!a_done && n < 500) begin tick(); n++; end
        check({tag, "_done_seen"}, 32'(a_done), 1);
        tick();
        check({tag, "_done_count"}, a_done_cnt, exp_cnt);
        check({tag, "_drained"}, q_a.size(), 0);
        check({tag, "_busy_low"}, 32'(a_busy), 0);
    endtask

    task automatic a_feed(input int d);
        int n = 0;
        a_pin_data = 16'(d); a_pin_valid = 1;
        while (!a_pin_ready && n < 100) begin tick(); n++; end
        check("a_psum_in_ready", 32'(a_pin_ready), 1);
        tick();
        a_pin_valid = 0;
    endtask

    initial begin
        int lat;
        int stable;
        int bf[6] = '{1, 2, 3, 1, 0, 1};

        // reset state
        #2;
        check("rst_flt_ready", 32'(a_flt_ready), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_data", 32'(a_out_data), 0);
        check("rst_busy", 32'(a_busy), 0);
        tick();
        rst_n = 1;
        tick();
        check("idle_flt_ready", 32'(a_flt_ready), 1);
        check("idle_if_ready", 32'(a_if_ready), 1);

        // basic run
        a_load_basic();
        a_push(14, 0); a_push(20, 1); a_push(26, 2);
        a_start_run(1'b0);
        check("basic_busy", 32'(a_busy), 1);
        a_wait_valid(lat);
        check("basic_first_latency", lat, 4);
        a_wait_done("basic", 1);

        // psum mode with an upstream stall
        a_push(114, 0); a_push(220, 1); a_push(326, 2);
        a_start_run(1'b1);
        repeat (5) tick();
        check("psum_stall_out_valid", 32'(a_out_valid), 0);
        check("psum_stall_in_ready", 32'(a_pin_ready), 1);
        a_feed(100); a_feed(200); a_feed(300);
        a_wait_done("psum", 2);

        // backpressure, ignored start, blocked loads
        a_out_ready = 0;
        a_push(14, 0); a_push(20, 1); a_push(26, 2);
        a_start_run(1'b0);
        a_wait_valid(lat);
        check("bp_first_latency", lat, 4);
        a_start = 1;
        a_flt_valid = 1; a_flt_addr = 0; a_flt_data = 77;
        a_if_valid = 1;  a_if_addr = 3;  a_if_data = 77;
        check("bp_flt_ready_busy", 32'(a_flt_ready), 0);
        check("bp_if_ready_busy", 32'(a_if_ready), 0);
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_out_valid === 1'b1 && a_out_data === 16'd14 && a_out_idx === 3'd0) stable++;
            tick();
            if (c == 0) begin a_start = 0; a_flt_valid = 0; a_if_valid = 0; end
        end
        check("bp_hold_stable", stable, 10);
        a_out_ready = 1;
        a_wait_done("bp", 3);
        repeat (6) tick();
        check("bp_no_queued_run", 32'(a_busy), 0);
        check("bp_no_stray_valid", 32'(a_out_valid), 0);

        // accumulator wrap at 16 bits
        for (int i = 0; i < 5; i++) a_write(i < 3, i, 255, 1'b1, i, 255);
        a_push(64003, 0); a_push(64003, 1); a_push(64003, 2);
        a_start_run(1'b0);
        a_wait_done("wrap", 4);

        // reset during MAC of the second output
        a_load_basic();
        a_push(14, 0);
        a_start_run(1'b0);
        a_wait_valid(lat);
        check("rst_run_first_latency", lat, 4);
        tick();
        tick();
        rst_n = 0;
        #1;
        check("midrst_out_valid", 32'(a_out_valid), 0);
        check("midrst_out_data", 32'(a_out_data), 0);
        check("midrst_busy", 32'(a_busy), 0);
        check("midrst_flt_ready", 32'(a_flt_ready), 0);
        repeat (3) tick();
        check("midrst_no_done", a_done_cnt, 4);
        rst_n = 1;
        tick();
        check("midrst_idle_ready", 32'(a_if_ready), 1);
        a_push(0, 0); a_push(0, 1); a_push(0, 2);
        a_start_run(1'b0);
        a_wait_done("cleared_mem", 5);
        a_load_basic();
        a_push(14, 0); a_push(20, 1); a_push(26, 2);
        a_start_run(1'b0);
        a_wait_done("rerun", 6);

        // stride 2, two filters
        for (int i = 0; i < 6; i++) begin
            b_flt_valid = 1; b_flt_addr = AW'(i); b_flt_data = DW'(bf[i]);
            b_if_valid = (i < 5); b_if_addr = AW'(i); b_if_data = DW'(i + 1);
            tick();
        end
        b_flt_valid = 0; b_if_valid = 0;
        q_b.push_back('{data: 14, idx: 0, flt: 0});
        q_b.push_back('{data: 26, idx: 1, flt: 0});
        q_b.push_back('{data: 4,  idx: 0, flt: 1});
        q_b.push_back('{data: 8,  idx: 1, flt: 1});
        b_start = 1;
        tick();
        b_start = 0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin tick(); lat++; end
        check("b_first_latency", lat, 4);
        lat = 0;
        while (!b_done && lat < 500) begin tick(); lat++; end
        check("b_done_seen", 32'(b_done), 1);
        tick();
        check("b_done_count", b_done_cnt, 1);
        check("b_drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
